wb_dest_pipe: RTL and testbench
===============================

// Module: wb_dest_pipe
// PURPOSE
//  Parametrised successor to the write-register destination select. Each cycle it picks the
//  destination register number from N_SRC instruction fields or two fixed constants ($ra, $sp).
//  The pick then travels through a DEPTH-stage tag pipeline (EX..WB) with stall and flush.
//  Every stage is compared against the current rs/rt, which drives forwarding/hazard logic.
//  The last stage drives the register-file write port.
// PARAMETERS
//  REG_AW   5   register-number width (32 regs)
//  N_SRC    3   number of instruction-field destination sources
//  SEL_W    3   width of sel; must satisfy 2**SEL_W >= N_SRC+2
//  DEPTH    3   pipeline stages tracked (stage 0 = EX, stage DEPTH-1 = WB)
//  CONST_RA 31  constant selected by sel == N_SRC
//  CONST_SP 29  constant selected by sel == N_SRC+1
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  sel        in   SEL_W         destination source select
//  src_flat   in   N_SRC*REG_AW  candidate fields; src k = src_flat[k*REG_AW +: REG_AW]
//  in_valid   in   1             issuing instruction is real (not a bubble)
//  reg_write  in   1             issuing instruction writes the register file
//  stall      in   1             hold all stages this cycle
//  flush      in   1             kill the issuing entry and stage 0
//  rs_in      in   REG_AW        source register A of the instruction now in decode
//  rt_in      in   REG_AW        source register B of the instruction now in decode
//  dest_q     out  DEPTH*REG_AW  per-stage destination; stage k = dest_q[k*REG_AW +: REG_AW]
//  valid_q    out  DEPTH         per-stage "will write" flag
//  wb_dest    out  REG_AW        = stage DEPTH-1 dest
//  wb_en      out  1             = valid_q[DEPTH-1]
//  hit_rs     out  DEPTH         hit_rs[k] = valid_q[k] && dest stage k == rs_in (combinational)
//  hit_rt     out  DEPTH         hit_rt[k] = valid_q[k] && dest stage k == rt_in (combinational)
//  illegal_sel out 1             sticky: a legal issue used sel > N_SRC+1
// BEHAVIOUR
//  - Select (combinational):
//    - sel < N_SRC: src[sel].
//    - sel == N_SRC: CONST_RA.
//    - sel == N_SRC+1: CONST_SP.
//    - Any other sel: value 0 and marked illegal.
//  - Issue: new_valid = in_valid && reg_write && !illegal.
//  - Reset (sync) clears on the next edge: all dest_q = 0, valid_q = 0, illegal_sel = 0.
//    Reset overrides stall and flush.
//  - Normal edge (!stall, !flush):
//    - stage 0 <= {new dest, new_valid};
//    - stage k <= stage k-1 for k >= 1;
//    - the old WB entry retires.
//  - Latency: an entry issued at edge N is in stage k after edge N+k; wb_en is high in cycle N+DEPTH-1.
//  - stall only: every stage holds; the issuing entry is not captured (upstream re-presents it).
//  - flush only: stage 0 <= {0, 0}; stages 1..DEPTH-1 advance normally.
//  - stall && flush: stage 0 <= {0, 0}; stages 1..DEPTH-1 hold.
//  - illegal_sel is set on an edge where in_valid && reg_write && sel illegal && !stall && !flush.
//    It holds until reset. Illegal entries always enter with valid = 0.
//  - Invalid stages keep their dest value but never assert hit_rs/hit_rt.
//  - DEPTH == 1: stage 0 is also WB.
// CONFIGURATION
//  ZERO_SUPPRESS_EN defined:
//    - an issue whose selected dest == 0 enters with valid = 0;
//    - $zero never produces wb_en or hits.
//  ZERO_SUPPRESS_EN undefined:
//    - dest 0 is tracked like any other register;
//    - hits on 0 are reported, and downstream logic masks them.
// TESTING
//  1) Issue sel=1, src1=5'd12, valid, reg_write over 3 edges (DEPTH=3) -> valid_q 001,011,111;
//     wb_dest=12 with wb_en=1 at cycle 2.
//  2) sel=3 and sel=4 back-to-back -> stage0 31 then 29.
//     rs_in=31 -> hit_rs=3'b010 after 2nd edge.
//  3) Load stage0=7, then assert stall 2 cycles -> dest_q and valid_q unchanged.
//     Deassert stall -> 7 moves to stage1.
//  4) stall+flush with stage0=9 valid, stage1=4 valid -> stage0 valid cleared; stage1 stays 4;
//     hit_rt for rt_in=9 = 0.
//  5) sel=7 with reg_write=1 -> entry valid=0; illegal_sel=1 and stays 1 until reset;
//     reset -> all outputs 0.
//  6) sel=0, src0=0: with ZERO_SUPPRESS_EN -> valid_q[0]=0;
//     without -> valid_q[0]=1 and hit_rs[0]=1 for rs_in=0.

Source files
------------

// File: rtl/wb_dest_pipe.sv
// Destination-register select feeding a DEPTH-stage tag pipeline with stall, flush and hit compare.
// Optional build macro ZERO_SUPPRESS_EN: issues targeting register 0 enter the pipe as invalid.
module wb_dest_pipe #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned N_SRC    = 3,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned CONST_RA = 31,
    parameter int unsigned CONST_SP = 29
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_SRC*REG_AW-1:0] src_flat,
    input  logic                    in_valid,
    input  logic                    reg_write,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [REG_AW-1:0]       rs_in,
    input  logic [REG_AW-1:0]       rt_in,
    output logic [DEPTH*REG_AW-1:0] dest_q,
    output logic [DEPTH-1:0]        valid_q,
    output logic [REG_AW-1:0]       wb_dest,
    output logic                    wb_en,
    output logic [DEPTH-1:0]        hit_rs,
    output logic [DEPTH-1:0]        hit_rt,
    output logic                    illegal_sel
);

    logic [DEPTH-1:0][REG_AW-1:0] stage_dest_q, stage_dest_d;
    logic [DEPTH-1:0]             stage_valid_q, stage_valid_d;
    logic                         illegal_q, illegal_d;
    logic [REG_AW-1:0]            sel_dest;
    logic                         sel_illegal;
    logic                         new_valid;

    always_comb begin
        sel_dest    = '0;
        sel_illegal = 1'b1;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_dest    = src_flat[k*REG_AW +: REG_AW];
                sel_illegal = 1'b0;
            end
        end
        if (sel == SEL_W'(N_SRC)) begin
            sel_dest    = REG_AW'(CONST_RA);
            sel_illegal = 1'b0;
        end else if (sel == SEL_W'(N_SRC + 1)) begin
            sel_dest    = REG_AW'(CONST_SP);
            sel_illegal = 1'b0;
        end
    end

`ifdef ZERO_SUPPRESS_EN
    assign new_valid = in_valid && reg_write && !sel_illegal && (sel_dest != '0);
`else
    assign new_valid = in_valid && reg_write && !sel_illegal;
`endif

    always_comb begin
        stage_dest_d  = stage_dest_q;
        stage_valid_d = stage_valid_q;
        if (!stall) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_dest_d[k]  = stage_dest_q[k-1];
                stage_valid_d[k] = stage_valid_q[k-1];
            end
        end
        // Flush kills stage 0 even while stalled; older stages follow stall alone.
        if (flush) begin
            stage_dest_d[0]  = '0;
            stage_valid_d[0] = 1'b0;
        end else if (!stall) begin
            stage_dest_d[0]  = sel_dest;
            stage_valid_d[0] = new_valid;
        end
        illegal_d = illegal_q | (in_valid && reg_write && sel_illegal && !stall && !flush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_dest_q  <= '0;
            stage_valid_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            stage_dest_q  <= stage_dest_d;
            stage_valid_q <= stage_valid_d;
            illegal_q     <= illegal_d;
        end
    end

    always_comb begin
        hit_rs = '0;
        hit_rt = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            hit_rs[k] = stage_valid_q[k] && (stage_dest_q[k] == rs_in);
            hit_rt[k] = stage_valid_q[k] && (stage_dest_q[k] == rt_in);
        end
    end

    assign dest_q      = stage_dest_q;
    assign valid_q     = stage_valid_q;
    assign wb_dest     = stage_dest_q[DEPTH-1];
    assign wb_en       = stage_valid_q[DEPTH-1];
    assign illegal_sel = illegal_q;

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Self-checking bench for wb_dest_pipe: directed scenarios plus random traffic vs. an array model.
module tb_wb_dest_pipe;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned N_SRC  = 3;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DEPTH  = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [SEL_W-1:0]        sel;
    logic [N_SRC*REG_AW-1:0] src_flat;
    logic                    in_valid, reg_write, stall, flush;
    logic [REG_AW-1:0]       rs_in, rt_in;
    logic [DEPTH*REG_AW-1:0] dest_q;
    logic [DEPTH-1:0]        valid_q, hit_rs, hit_rt;
    logic [REG_AW-1:0]       wb_dest;
    logic                    wb_en, illegal_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one entry per stage, index 0 = EX.
    int m_dest [DEPTH];
    bit m_valid[DEPTH];
    bit m_ill;

    always #5 clk = ~clk;

    wb_dest_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .src_flat   (src_flat),
        .in_valid   (in_valid),
        .reg_write  (reg_write),
        .stall      (stall),
        .flush      (flush),
        .rs_in      (rs_in),
        .rt_in      (rt_in),
        .dest_q     (dest_q),
        .valid_q    (valid_q),
        .wb_dest    (wb_dest),
        .wb_en      (wb_en),
        .hit_rs     (hit_rs),
        .hit_rt     (hit_rt),
        .illegal_sel(illegal_sel)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  d;
        bit  bad;
        bit  nv;
        int  s;
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_dest[k]  = 0;
                m_valid[k] = 0;
            end
            m_ill = 0;
        end else begin
            s   = int'(sel);
            bad = 0;
            if (s < N_SRC) d = int'(src_flat[s*REG_AW +: REG_AW]);
            else if (s == N_SRC) d = 31;
            else if (s == N_SRC + 1) d = 29;
            else begin
                d   = 0;
                bad = 1;
            end
            nv = in_valid && reg_write && !bad;
`ifdef ZERO_SUPPRESS_EN
            if (d == 0) nv = 0;
`endif
            if (!stall) begin
                for (int k = DEPTH - 1; k >= 1; k--) begin
                    m_dest[k]  = m_dest[k-1];
                    m_valid[k] = m_valid[k-1];
                end
            end
            if (flush) begin
                m_dest[0]  = 0;
                m_valid[0] = 0;
            end else if (!stall) begin
                m_dest[0]  = d;
                m_valid[0] = nv;
            end
            if (in_valid && reg_write && bad && !stall && !flush) m_ill = 1;
        end
    endtask

    task automatic compare_all();
        logic [DEPTH*REG_AW-1:0] e_dest;
        logic [DEPTH-1:0]        e_valid, e_rs, e_rt;
        for (int k = 0; k < DEPTH; k++) begin
            e_dest[k*REG_AW +: REG_AW] = REG_AW'(m_dest[k]);
            e_valid[k] = m_valid[k];
            e_rs[k]    = m_valid[k] && (m_dest[k] == int'(rs_in));
            e_rt[k]    = m_valid[k] && (m_dest[k] == int'(rt_in));
        end
        check("dest_q", 64'(dest_q), 64'(e_dest));
        check("valid_q", 64'(valid_q), 64'(e_valid));
        check("wb_dest", 64'(wb_dest), 64'(m_dest[DEPTH-1]));
        check("wb_en", 64'(wb_en), 64'(m_valid[DEPTH-1]));
        check("hit_rs", 64'(hit_rs), 64'(e_rs));
        check("hit_rt", 64'(hit_rt), 64'(e_rt));
        check("illegal_sel", 64'(illegal_sel), 64'(m_ill));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input int s, input int f0, input int f1, input int f2,
                         input bit iv, input bit rw, input bit st, input bit fl,
                         input int rs, input int rt);
        sel       = SEL_W'(s);
        src_flat  = {REG_AW'(f2), REG_AW'(f1), REG_AW'(f0)};
        in_valid  = iv;
        reg_write = rw;
        stall     = st;
        flush     = fl;
        rs_in     = REG_AW'(rs);
        rt_in     = REG_AW'(rt);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) begin
            m_dest[k]  = 0;
            m_valid[k] = 0;
        end
        m_ill = 0;
        cycle();
        cycle();
        check("rst_dest", 64'(dest_q), 64'd0);
        check("rst_valid", 64'(valid_q), 64'd0);
        reset = 1'b0;

        // Pick src1 = 12 on three consecutive edges.
        drive(1, 0, 12, 0, 1, 1, 0, 0, 0, 0);
        cycle();
        check("t1_v0", 64'(valid_q), 64'b001);
        cycle();
        check("t1_v1", 64'(valid_q), 64'b011);
        cycle();
        check("t1_v2", 64'(valid_q), 64'b111);
        check("t1_wbd", 64'(wb_dest), 64'd12);
        check("t1_wben", 64'(wb_en), 64'd1);

        // $ra then $sp.
        drive(3, 0, 0, 0, 1, 1, 0, 0, 31, 0);
        cycle();
        check("t2_s0ra", 64'(dest_q[4:0]), 64'd31);
        drive(4, 0, 0, 0, 1, 1, 0, 0, 31, 0);
        cycle();
        check("t2_s0sp", 64'(dest_q[4:0]), 64'd29);
        check("t2_hitrs", 64'(hit_rs), 64'b010);

        // Stall holds everything.
        drive(0, 7, 0, 0, 1, 1, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 3, 0, 1, 1, 1, 0, 0, 0);
        cycle();
        cycle();
        check("t3_s0hold", 64'(dest_q[4:0]), 64'd7);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("t3_s1", 64'(dest_q[9:5]), 64'd7);

        // stall + flush: stage 0 killed, stage 1 holds.
        drive(0, 4, 0, 0, 1, 1, 0, 0, 0, 9);
        cycle();
        drive(0, 9, 0, 0, 1, 1, 0, 0, 0, 9);
        cycle();
        drive(0, 9, 0, 0, 1, 1, 1, 1, 0, 9);
        cycle();
        check("t4_v0", 64'(valid_q[0]), 64'd0);
        check("t4_s1", 64'(dest_q[9:5]), 64'd4);
        check("t4_hitrt", 64'(hit_rt), 64'd0);

        // Illegal select is sticky until reset.
        drive(7, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        cycle();
        check("t5_v0", 64'(valid_q[0]), 64'd0);
        check("t5_ill", 64'(illegal_sel), 64'd1);
        drive(2, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        cycle();
        check("t5_sticky", 64'(illegal_sel), 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t5_rst", 64'({dest_q, valid_q, illegal_sel}), 64'd0);

        // Destination $zero.
        drive(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        cycle();
`ifdef ZERO_SUPPRESS_EN
        check("t6_v0", 64'(valid_q[0]), 64'd0);
        check("t6_hit", 64'(hit_rs[0]), 64'd0);
`else
        check("t6_v0", 64'(valid_q[0]), 64'd1);
        check("t6_hit", 64'(hit_rs[0]), 64'd1);
`endif

        // Random traffic; small register values so hits happen often.
        for (int i = 0; i < 600; i++) begin
            drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            reset = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
